// File: rtl/fifo_rd_port.sv
// -----------------------------------------------------------------------------
// fifo_rd_port
//
// Read side of the fifo_mem storage array, the mirror of the write demux.
// Picks one stored word by read pointer (N:1 mux) into a registered output
// stage. The word is presented through a valid/ready handshake. The read
// pointer is compared with the write side's pointer to derive empty and
// occupancy.
//
// Parameters
//   bits   word width
//   depth  number of entries (need not be a power of two, must be >= 2)
//
// Pointers are {lap, index}: PW = $clog2(depth)+1 bits. The index counts
// 0..depth-1. The lap bit toggles on every wrap, which tells full and empty
// apart when the indices are equal.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   mem_nm    in   flattened storage contents, entry i = mem_nm[i*bits +: bits]
//   wr_ptr    in   write pointer from the write side
//   rd_ptr    out  read pointer to the write side (used for full detection)
//   rd_ready  in   consumer accepts out_n this cycle
//   rd_valid  out  out_n holds a valid word
//   out_n     out  registered read data
//   empty     out  no unfetched entries in storage (combinational)
//   count     out  unfetched entries in storage, 0..depth; the output
//                  register is not counted
//   err       out  (FIFO_RD_ERR_EN only) sticky pointer-consistency error
//
// Optional feature macro: FIFO_RD_ERR_EN
//   When defined, the err port is added. An inconsistent wr_ptr sets err:
//   either its index is out of range, or it implies an occupancy above depth.
//   err stays set until rst. While err is set, fetching stops, so rd_ptr and
//   out_n freeze. A pending word can still be handed off.
// -----------------------------------------------------------------------------
module fifo_rd_port #(
    parameter int unsigned bits  = 8,
    parameter int unsigned depth = 10,
    localparam int unsigned PW   = $clog2(depth) + 1,
    localparam int unsigned CW   = $clog2(depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [depth*bits-1:0] mem_nm,
    input  logic [PW-1:0]         wr_ptr,
    output logic [PW-1:0]         rd_ptr,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [bits-1:0]       out_n,
    output logic                  empty,
`ifdef FIFO_RD_ERR_EN
    output logic                  err,
`endif
    output logic [CW-1:0]         count
);

    localparam int unsigned IW = PW - 1;

    // State registers
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            valid_q, valid_d;
    logic [bits-1:0] data_q, data_d;

    // Pointer fields
    logic          r_lap, w_lap;
    logic [IW-1:0] r_idx, w_idx;

    logic            fetch;
    logic            halt;
    logic [bits-1:0] sel_word;
    logic [PW-1:0]   rd_ptr_inc;

    assign r_lap = rd_ptr_q[PW-1];
    assign r_idx = rd_ptr_q[IW-1:0];
    assign w_lap = wr_ptr[PW-1];
    assign w_idx = wr_ptr[IW-1:0];

    // Full compare of lap and index.
    assign empty = (rd_ptr_q == wr_ptr);

    // Modular arithmetic in CW bits is exact: a legal result lies in
    // 0..depth, and that range always fits in CW bits.
    always_comb begin
        if (r_lap == w_lap) begin
            count = CW'(w_idx) - CW'(r_idx);
        end else begin
            count = CW'(depth) - CW'(r_idx) + CW'(w_idx);
        end
    end

    // -------------------------------------------------------------------------
    // Optional pointer-consistency checking
    // -------------------------------------------------------------------------
`ifdef FIFO_RD_ERR_EN
    logic err_q, err_d;
    logic err_cond;

    // The index is compared one bit wider, so depth == 2**IW does not alias to 0.
    assign err_cond = ({1'b0, w_idx} >= (IW + 1)'(depth)) ||
                      ((r_lap != w_lap) && (w_idx > r_idx));

    assign err_d = err_q | err_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Also stop on the cycle the bad pointer first appears, so no word is
    // fetched from a nonsense address.
    assign halt = err_q | err_cond;
    assign err  = err_q;
`else
    assign halt = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read mux: only the entry addressed by r_idx is looked at. A compare
    // loop keeps an out-of-range index from producing an out-of-range slice.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < int'(depth); i++) begin
            if (r_idx == IW'(i)) begin
                sel_word = mem_nm[i*bits +: bits];
            end
        end
    end

    // Advance with wrap: index depth-1 goes to 0, and the lap bit flips.
    always_comb begin
        if (r_idx == IW'(depth - 1)) begin
            rd_ptr_inc = {~r_lap, {IW{1'b0}}};
        end else begin
            rd_ptr_inc = {r_lap, r_idx + IW'(1)};
        end
    end

    // Fetch when storage holds a word and the output slot is free or is
    // being emptied this cycle.
    assign fetch = !empty && (!valid_q || rd_ready) && !halt;

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;

        if (fetch) begin
            rd_ptr_d = rd_ptr_inc;
            valid_d  = 1'b1;
            data_d   = sel_word;
        end else if (valid_q && rd_ready) begin
            // Handshake with nothing to refill: drop valid, keep the stale data.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign rd_ptr   = rd_ptr_q;
    assign rd_valid = valid_q;
    assign out_n    = data_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_port
//
// Directed bench for fifo_rd_port with bits=8 and depth=10. One task per
// scenario. Inputs change 1 time unit after the rising edge, and outputs are
// checked at that same point.
// -----------------------------------------------------------------------------
module tb_fifo_rd_port;

    localparam int unsigned BITS  = 8;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst;
    logic [DEPTH*BITS-1:0] mem_nm;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [BITS-1:0]       out_n;
    logic                  empty;
    logic [CW-1:0]         count;
`ifdef FIFO_RD_ERR_EN
    logic                  err;
`endif

    logic [BITS-1:0] mem [DEPTH];

    int pass_cnt;
    int total_cnt;

    fifo_rd_port #(
        .bits  (BITS),
        .depth (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_nm   (mem_nm),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .out_n    (out_n),
        .empty    (empty),
`ifdef FIFO_RD_ERR_EN
        .err      (err),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_nm = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_nm[i*BITS +: BITS] = mem[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge with the given write pointer, then release.
    task automatic do_reset(input logic [PW-1:0] wp);
        rst    = 1'b1;
        wr_ptr = wp;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rd_ready = 1'b0;
        rst      = 1'b1;
        wr_ptr   = 5'd3;
        tick();
        total_cnt++;
        if (rd_ptr !== 5'd0) $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr);
        else pass_cnt++;
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_n !== 8'h00) $display("FAIL reset_out_n got=%h exp=00", out_n);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (empty !== 1'b0) $display("FAIL reset_empty got=%b exp=0", empty);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd3) $display("FAIL reset_count got=%0d exp=3", count);
        else pass_cnt++;
    endtask

    task automatic test_single();
        rd_ready = 1'b1;
        mem[0]   = 8'hA5;
        do_reset(5'd0);
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL single_empty0 got=%b exp=1", empty);
        else pass_cnt++;
        wr_ptr = 5'd1;  // advance at edge N
        tick();         // edge N+1
        total_cnt++;
        if (rd_valid !== 1'b1 || out_n !== 8'hA5 || rd_ptr !== 5'd1)
            $display("FAIL single_fetch got v=%b d=%h p=%0d exp v=1 d=a5 p=1",
                     rd_valid, out_n, rd_ptr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || out_n !== 8'hA5)
            $display("FAIL single_drain got v=%b e=%b d=%h exp v=0 e=1 d=a5",
                     rd_valid, empty, out_n);
        else pass_cnt++;
    endtask

    task automatic test_full_drain();
        rd_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'(10 + i);
        do_reset(5'b10000);
        total_cnt++;
        if (count !== 4'd10 || empty !== 1'b0)
            $display("FAIL full_count got c=%0d e=%b exp c=10 e=0", count, empty);
        else pass_cnt++;
        rd_ready = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            tick();
            total_cnt++;
            if (rd_valid !== 1'b1 || out_n !== 8'(10 + k))
                $display("FAIL full_word%0d got v=%b d=%0d exp v=1 d=%0d",
                         k, rd_valid, out_n, 10 + k);
            else pass_cnt++;
        end
        total_cnt++;
        if (rd_ptr !== 5'b10000 || empty !== 1'b1 || count !== 4'd0)
            $display("FAIL full_end got p=%b e=%b c=%0d exp p=10000 e=1 c=0",
                     rd_ptr, empty, count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0;
        mem[0] = 8'h31;
        mem[1] = 8'h32;
        mem[2] = 8'h33;
        do_reset(5'd3);
        tick();
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (rd_valid !== 1'b1 || out_n !== 8'h31 || rd_ptr !== 5'd1 || count !== 4'd2)
                $display("FAIL bp_hold%0d got v=%b d=%h p=%0d c=%0d exp v=1 d=31 p=1 c=2",
                         k, rd_valid, out_n, rd_ptr, count);
            else pass_cnt++;
            tick();
        end
        rd_ready = 1'b1;
        tick();
        total_cnt++;
        if (rd_valid !== 1'b1 || out_n !== 8'h32)
            $display("FAIL bp_word1 got v=%b d=%h exp v=1 d=32", rd_valid, out_n);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rd_valid !== 1'b1 || out_n !== 8'h33 || rd_ptr !== 5'd3 || empty !== 1'b1)
            $display("FAIL bp_word2 got v=%b d=%h p=%0d e=%b exp v=1 d=33 p=3 e=1",
                     rd_valid, out_n, rd_ptr, empty);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL bp_drain got v=%b exp v=0", rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        rd_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'(i);
        do_reset(5'd9);
        for (int k = 0; k < 9; k++) tick();
        total_cnt++;
        if (rd_ptr !== 5'd9 || empty !== 1'b1)
            $display("FAIL wrap_setup got p=%0d e=%b exp p=9 e=1", rd_ptr, empty);
        else pass_cnt++;
        mem[9] = 8'h99;
        mem[0] = 8'hC0;
        wr_ptr = 5'b10001;
        #1;
        total_cnt++;
        if (count !== 4'd2) $display("FAIL wrap_count got=%0d exp=2", count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_n !== 8'h99 || rd_ptr !== 5'b10000)
            $display("FAIL wrap_word9 got d=%h p=%b exp d=99 p=10000", out_n, rd_ptr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_n !== 8'hC0 || rd_ptr !== 5'b10001 || empty !== 1'b1)
            $display("FAIL wrap_word0 got d=%h p=%b e=%b exp d=c0 p=10001 e=1",
                     out_n, rd_ptr, empty);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        rd_ready = 1'b0;
        mem[0]   = 8'h77;
        do_reset(5'd2);
        tick();
        tick();
        total_cnt++;
        if (rd_valid !== 1'b1 || out_n !== 8'h77)
            $display("FAIL midrst_pre got v=%b d=%h exp v=1 d=77", rd_valid, out_n);
        else pass_cnt++;
        rst = 1'b1;
        #1;  // no clock edge: reset must act asynchronously
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_ptr !== 5'd0 || out_n !== 8'h00)
            $display("FAIL midrst_async got v=%b p=%0d d=%h exp v=0 p=0 d=00",
                     rd_valid, rd_ptr, out_n);
        else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

`ifdef FIFO_RD_ERR_EN
    task automatic test_err();
        rd_ready = 1'b1;
        do_reset(5'd0);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_reset got=%b exp=0", err);
        else pass_cnt++;
        wr_ptr = 5'd12;
        tick();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err);
        else pass_cnt++;
        wr_ptr = 5'd2;
        tick();
        tick();
        total_cnt++;
        if (err !== 1'b1 || rd_valid !== 1'b0 || rd_ptr !== 5'd0)
            $display("FAIL err_sticky got err=%b v=%b p=%0d exp err=1 v=0 p=0",
                     err, rd_valid, rd_ptr);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        rd_ready  = 1'b0;
        wr_ptr    = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

        test_reset();
        test_single();
        test_full_drain();
        test_backpressure();
        test_wrap();
        test_mid_reset();
`ifdef FIFO_RD_ERR_EN
        test_err();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
